// File: rtl/log2lin_interp_pipe.sv
// log2lin_interp_pipe: log-domain attenuation address to sign/magnitude linear
// sample for the VM2413 operator output path.
// Three-stage pipeline: S1 table lookup, S2 linear interpolation, S3 output register.
// Optional build macro LT_ROUND_EN: when defined, the interpolation step rounds
// half-up instead of using floor. When it is undefined, the floor result is
// bit-exact with the legacy 128x9 converter.
//
// Handshake: a sample moves in on a clock edge where in_valid & in_ready are
// both high, and moves out on an edge where out_valid & out_ready are both high.
// in_ready depends only on out_valid and out_ready. While out_valid is high and
// out_ready is low, the whole pipe holds and the out_* signals keep their values.
module log2lin_interp_pipe #(
  parameter int INT_W         = 7,
  parameter int FRAC_W        = 6,
  parameter int DATA_W        = 9,
  parameter int STEPS_PER_OCT = 16,
  parameter int CH_W          = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W+FRAC_W:0]     in_addr,
  input  logic [CH_W-1:0]           in_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [DATA_W-1:0]         out_value,
  output logic [CH_W-1:0]           out_ch
);

  localparam int DEPTH = 1 << INT_W;
  localparam int PW    = DATA_W + FRAC_W + 2;

  // Exponential table entry. The last entry is forced to zero so that the
  // deepest attenuation is fully silent.
  function automatic int tbl_entry(input int i);
    real v;
    if (i >= DEPTH - 1) return 0;
    v = ((2.0 ** DATA_W) - 1.0) * (2.0 ** (-real'(i) / real'(STEPS_PER_OCT)));
    return $rtoi(v + 0.5);
  endfunction

  logic [DATA_W-1:0] lut [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    localparam int E = tbl_entry(g);
    assign lut[g] = DATA_W'(E);
  end

  // Split the address into its fields. The neighbour index stays at the last
  // entry, so interpolation at the end of the table is flat.
  logic              a_sign;
  logic [INT_W-1:0]  a_idx;
  logic [INT_W-1:0]  a_idx_n;
  logic [FRAC_W-1:0] a_w;

  assign a_sign  = in_addr[INT_W+FRAC_W];
  assign a_idx   = in_addr[INT_W+FRAC_W-1:FRAC_W];
  assign a_w     = in_addr[FRAC_W-1:0];
  assign a_idx_n = (&a_idx) ? a_idx : a_idx + INT_W'(1);

  logic stall;
  logic en;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  // S1 registers: both table neighbours plus the fields that travel with the sample.
  logic              s1_valid;
  logic              s1_sign;
  logic [FRAC_W-1:0] s1_w;
  logic [CH_W-1:0]   s1_ch;
  logic [DATA_W-1:0] s1_d0;
  logic [DATA_W-1:0] s1_d1;

  // S1: capture the lookup. Bubbles are captured like data and carry valid = 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_w     <= '0;
      s1_ch    <= '0;
      s1_d0    <= '0;
      s1_d1    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= a_sign;
      s1_w     <= a_w;
      s1_ch    <= in_ch;
      s1_d0    <= lut[a_idx];
      s1_d1    <= lut[a_idx_n];
    end
  end

  // Interpolation. The table falls monotonically, so diff is zero or negative.
  // The result stays inside [d1, d0] and needs no clamping.
  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_r;
  logic [DATA_W-1:0]      inter;

`ifdef LT_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC_W - 1));
`endif

  // S2 datapath: signed difference, scaling by the weight, then shift and add back onto d0.
  always_comb begin
    diff = $signed({1'b0, s1_d1}) - $signed({1'b0, s1_d0});
    prod = PW'(diff) * PW'($signed({1'b0, s1_w}));
`ifdef LT_ROUND_EN
    prod_r = prod + HALF;
`else
    prod_r = prod;
`endif
    inter = DATA_W'($signed({1'b0, s1_d0}) + (prod_r >>> FRAC_W));
  end

  logic              s2_valid;
  logic              s2_sign;
  logic [CH_W-1:0]   s2_ch;
  logic [DATA_W-1:0] s2_val;

  // S2: register the interpolated magnitude together with its sign and tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_ch    <= '0;
      s2_val   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_ch    <= s1_ch;
      s2_val   <= inter;
    end
  end

  // S3: output register. It holds while downstream is not accepting the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_ch    <= '0;
      out_value <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_sign  <= s2_sign;
      out_ch    <= s2_ch;
      out_value <= s2_val;
    end
  end

endmodule

// File: tb/tb_log2lin_interp_pipe.sv
// Testbench for log2lin_interp_pipe. It runs directed cases for the table
// corners, latency, backpressure and asynchronous reset, then randomized
// traffic. A negedge monitor scores every output against an arithmetic model.
module tb_log2lin_interp_pipe;

  localparam int INT_W  = 7;
  localparam int FRAC_W = 6;
  localparam int DATA_W = 9;
  localparam int SPO    = 16;
  localparam int CH_W   = 5;
  localparam int DEPTH  = 1 << INT_W;
  localparam int W      = 1 + CH_W + DATA_W;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [INT_W+FRAC_W:0] in_addr = '0;
  logic [CH_W-1:0]       in_ch = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic                  out_sign;
  logic [DATA_W-1:0]     out_value;
  logic [CH_W-1:0]       out_ch;

  log2lin_interp_pipe #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W),
    .STEPS_PER_OCT(SPO), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_value(out_value), .out_ch(out_ch)
  );

  int nchecks = 0;
  int nerrors = 0;
  int tab [DEPTH];
  logic [W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: d0 + (d1-d0)*w/2^FRAC_W, rounded down (or half-up when built that way).
  function automatic int model_val(input int idx, input int w);
    int d0, d1, p;
    d0 = tab[idx];
    d1 = (idx == DEPTH - 1) ? tab[idx] : tab[idx + 1];
    p  = (d1 - d0) * w;
`ifdef LT_ROUND_EN
    p = p + (1 << (FRAC_W - 1));
`endif
    return d0 + fdiv(p, 1 << FRAC_W);
  endfunction

  // Scoreboard monitor: inputs and outputs are sampled mid-cycle, before the edge that transfers them.
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_val;
  logic [CH_W-1:0]   prev_ch;
  logic              prev_sign;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      logic [W-1:0] e;
      check_eq("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (hold_prev) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_value", out_value, prev_val);
        check_eq("hold_ch", out_ch, prev_ch);
        check_eq("hold_sign", out_sign, prev_sign);
      end
      hold_prev = out_valid && !out_ready;
      prev_val  = out_value;
      prev_ch   = out_ch;
      prev_sign = out_sign;
      if (out_valid && out_ready) begin
        check_eq("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_sign", out_sign, e[W-1]);
          check_eq("sb_ch", out_ch, e[W-2 -: CH_W]);
          check_eq("sb_value", out_value, e[DATA_W-1:0]);
        end
      end
      if (in_valid && in_ready) begin
        e = {in_addr[INT_W+FRAC_W], in_ch,
             DATA_W'(model_val(int'(in_addr[INT_W+FRAC_W-1:FRAC_W]), int'(in_addr[FRAC_W-1:0])))};
        exp_q.push_back(e);
      end
    end
  end

  // Driver: present one sample and keep it stable until the pipe accepts it.
  task automatic send(input logic s, input int idx, input int w, input int ch);
    int n;
    logic acc;
    in_valid = 1'b1;
    in_addr  = {s, INT_W'(idx), FRAC_W'(w)};
    in_ch    = CH_W'(ch);
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    check_eq("send_accept", acc, 1);
  endtask

  // One sample into an empty pipe. Checks latency and the result against constants.
  task automatic single(input string tag, input logic s, input int idx, input int w,
                        input int ch, input int exp_val);
    int cyc;
    send(s, idx, w, ch);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, 3);
    check_eq({tag, "_value"}, out_value, exp_val);
    check_eq({tag, "_sign"}, out_sign, s);
    check_eq({tag, "_ch"}, out_ch, ch);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      tab[i] = (i == DEPTH - 1) ? 0
             : $rtoi(((2.0 ** DATA_W) - 1.0) * (2.0 ** (-real'(i) / real'(SPO))) + 0.5);

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_value", out_value, 0);
    check_eq("rst_out_sign", out_sign, 0);
    check_eq("rst_out_ch", out_ch, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table corners and interpolation
    single("t1_idx0", 1'b0, 0, 0, 3, 511);
`ifdef LT_ROUND_EN
    single("t2_w16", 1'b0, 0, 16, 4, 506);
`else
    single("t2_w16", 1'b0, 0, 16, 4, 505);
`endif
    single("t3_idx127", 1'b1, 127, 63, 5, 0);
    single("t3_idx126", 1'b0, 126, 32, 6, 1);
    single("t4_idx1", 1'b0, 1, 0, 7, 489);
    single("t4_idx15", 1'b1, 15, 0, 8, 267);
    single("t4_idx16", 1'b0, 16, 0, 9, 256);
    single("t4_idx126", 1'b0, 126, 0, 10, 2);

    // Back-to-back stream of idx 0..15: expect 16 consecutive outputs in order
    fork
      begin
        for (int i = 0; i < 16; i++) send(1'b0, i, 0, i);
        in_valid = 1'b0;
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clk);
          check_eq("stream_valid", out_valid, 1);
          check_eq("stream_value", out_value, tab[i]);
          check_eq("stream_ch", out_ch, i);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Backpressure mid-stream: out_ready low for 5 cycles
    fork
      begin
        for (int i = 0; i < 12; i++)
          send($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 63), i + 16);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check_eq("bp_drained", exp_q.size(), 0);

    // Asynchronous reset with three samples in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 20 + i, 10, 25 + i);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_value", out_value, 0);
    check_eq("mid_rst_out_sign", out_sign, 0);
    check_eq("mid_rst_out_ch", out_ch, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    single("t6_after_rst", 1'b0, 40, 17, 11, model_val(40, 17));

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      logic acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_addr  = {1'($urandom_range(0, 1)), INT_W'($urandom_range(0, DEPTH - 1)),
                    FRAC_W'($urandom_range(0, 63))};
        in_ch    = CH_W'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check_eq("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
